// File: rtl/node_lookup_arbiter.sv
// node_lookup_arbiter: shares one node_tree engine between NUM_REQ
// field-id streams, locking the engine to one requester per message.
package node_lookup_pkg;
  typedef logic [7:0]  identifier;
  typedef logic [15:0] node_data;
  localparam node_data null_node_data = '0;
endpackage

module node_lookup_arbiter
  import node_lookup_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  identifier [NUM_REQ-1:0]   req_field_id_i,
  input  logic      [NUM_REQ-1:0]   req_valid_i,
  input  logic      [NUM_REQ-1:0]   req_last_i,
  output logic      [NUM_REQ-1:0]   req_rdy_o,
  output node_data                  rsp_node_o,
  output logic      [NUM_REQ-1:0]   rsp_valid_o,
  input  logic      [NUM_REQ-1:0]   rsp_rdy_i,
  output identifier                 eng_field_id_o,
  output logic                      eng_field_id_valid_o,
  input  logic                      eng_field_id_rdy_i,
  input  node_data                  eng_node_i,
  input  logic                      eng_node_valid_i,
  output logic                      eng_node_rdy_o,
  output logic      [NUM_REQ-1:0]   grant_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [REQ_W-1:0]     r_owner;
  logic [REQ_W-1:0]     r_rr_ptr;
  logic [REQ_W-1:0]     w_win;
  logic [REQ_W-1:0]     w_owner_inc;
  logic                 r_last;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_err;
  logic                 w_start;
  logic                 w_fid_hs;
  logic                 w_rsp_hs;
  logic                 w_null;
  logic                 w_release;

  function automatic logic [REQ_W-1:0] f_idx(
    input logic [REQ_W-1:0] base,
    input int               off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[REQ_W-1:0];
  endfunction

  assign w_start   = (r_state == IDLE) && (|req_valid_i);
  assign w_fid_hs  = (r_state == ISSUE) && req_valid_i[r_owner]
                   && eng_field_id_rdy_i;
  assign w_null    = (eng_node_i == null_node_data);
  assign w_rsp_hs  = (r_state == WAIT_RSP) && eng_node_valid_i
                   && rsp_rdy_i[r_owner];
  assign w_release = w_rsp_hs && (r_last || w_null);

  assign w_owner_inc = (int'(r_owner) == NUM_REQ - 1) ?
                       '0 : r_owner + REQ_W'(1);

  assign grant_o = r_grant;
  assign err_o   = r_err;

  // rotated-priority search: lowest offset from rr_ptr wins
  always_comb begin
    w_win = r_rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[f_idx(r_rr_ptr, i)]) w_win = f_idx(r_rr_ptr, i);
    end
  end

  // next state and owner-routed pass-through paths
  always_comb begin
    w_state_nxt          = r_state;
    eng_field_id_o       = '0;
    eng_field_id_valid_o = 1'b0;
    req_rdy_o            = '0;
    rsp_node_o           = '0;
    rsp_valid_o          = '0;
    eng_node_rdy_o       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        eng_field_id_o       = req_field_id_i[r_owner];
        eng_field_id_valid_o = req_valid_i[r_owner];
        req_rdy_o[r_owner]   = eng_field_id_rdy_i;
        if (w_fid_hs) w_state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        rsp_node_o           = eng_node_i;
        rsp_valid_o[r_owner] = eng_node_valid_i;
        eng_node_rdy_o       = rsp_rdy_i[r_owner];
        if (w_rsp_hs) w_state_nxt = w_release ? IDLE : ISSUE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // owner lock, rotation pointer, last-field flag and error pulse
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_last   <= 1'b0;
      r_grant  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_rsp_hs && w_null;
      if (w_start) begin
        r_owner <= w_win;
        r_grant <= NUM_REQ'(1) << w_win;
      end
      if (w_fid_hs) r_last <= req_last_i[r_owner];
      if (w_release) begin
        r_grant  <= '0;
        r_rr_ptr <= w_owner_inc;
      end
    end
  end

endmodule

// File: tb/tb_node_lookup_arbiter.sv
// tb_node_lookup_arbiter: directed and random checks of the engine
// arbiter against a message-level model and a delayed engine model.
`timescale 1ns/1ps
module tb_node_lookup_arbiter;
  import node_lookup_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  identifier [N-1:0] req_field_id_i;
  logic [N-1:0] req_valid_i, req_last_i, req_rdy_o;
  logic [N-1:0] rsp_valid_o, rsp_rdy_i, grant_o;
  node_data rsp_node_o, eng_node_i;
  identifier eng_field_id_o;
  logic eng_field_id_valid_o, eng_field_id_rdy_i;
  logic eng_node_valid_i, eng_node_rdy_o, err_o;

  node_lookup_arbiter #(.NUM_REQ(N)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .req_field_id_i(req_field_id_i),
    .req_valid_i(req_valid_i),
    .req_last_i(req_last_i),
    .req_rdy_o(req_rdy_o),
    .rsp_node_o(rsp_node_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdy_i(rsp_rdy_i),
    .eng_field_id_o(eng_field_id_o),
    .eng_field_id_valid_o(eng_field_id_valid_o),
    .eng_field_id_rdy_i(eng_field_id_rdy_i),
    .eng_node_i(eng_node_i),
    .eng_node_valid_i(eng_node_valid_i),
    .eng_node_rdy_o(eng_node_rdy_o),
    .grant_o(grant_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  identifier q_id [N][$];
  bit q_last [N][$];
  bit open_m [N];
  bit pause [N];
  int rsp_cnt [N];

  int m_owner, m_rr, m_nulls, err_seen, e_cnt, e_delay;
  bit m_out, m_last, m_err, rnd, spur, e_busy, e_nv;
  identifier m_id, e_id;
  logic [N-1:0] rdy_block;
  logic [N-1:0] g_log [$];

  function automatic node_data nodef(identifier id);
    return (id == 8'hFF) ? null_node_data : {~id, id};
  endfunction

  function automatic int winner(logic [N-1:0] v, int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(int o);
    return (o < 0) ? '0 : (N'(1) << o);
  endfunction

  function automatic logic [63:0] outs();
    return {25'd0, grant_o, req_rdy_o, rsp_valid_o,
            eng_field_id_valid_o, eng_node_rdy_o, err_o,
            rsp_node_o, eng_field_id_o};
  endfunction

  function automatic bit all_empty();
    for (int r = 0; r < N; r++)
      if (q_id[r].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int r, identifier id, bit last);
    q_id[r].push_back(id);
    q_last[r].push_back(last);
  endtask

  task automatic pop(int r);
    void'(q_id[r].pop_front());
    void'(q_last[r].pop_front());
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (rnd) pause[r] = ($urandom_range(0, 7) == 0);
      req_valid_i[r] = (q_id[r].size() > 0) && !pause[r];
      req_field_id_i[r] = (q_id[r].size() > 0) ? q_id[r][0] : '0;
      req_last_i[r] = (q_last[r].size() > 0) ? q_last[r][0] : 1'b0;
    end
    rsp_rdy_i = (rnd ? N'($urandom) : '1) & ~rdy_block;
    eng_field_id_rdy_i = !e_busy;
    eng_node_valid_i = e_nv | spur;
    eng_node_i = e_nv ? nodef(e_id) : '0;
  endtask

  task automatic step();
    int o, oi, arb;
    bit x_ev, x_nrdy, fld_hs, rsp_hs, is_null, e_acc, e_del;
    logic [N-1:0] x_grant, x_rrdy, x_rv;
    node_data x_node;
    identifier e_fid;
    @(negedge clk);
    o = m_owner;
    oi = (o < 0) ? 0 : o;
    x_grant = oh(o);
    x_ev = (o >= 0) && !m_out && req_valid_i[oi];
    x_rrdy = ((o >= 0) && !m_out && eng_field_id_rdy_i) ? oh(o) : '0;
    x_rv = ((o >= 0) && m_out && eng_node_valid_i) ? oh(o) : '0;
    x_nrdy = (o >= 0) && m_out && rsp_rdy_i[oi];
    x_node = ((o >= 0) && m_out) ? eng_node_i : '0;
    chk("cycle",
        {grant_o, req_rdy_o, rsp_valid_o, eng_field_id_valid_o,
         eng_node_rdy_o, err_o, rsp_node_o},
        {x_grant, x_rrdy, x_rv, x_ev, x_nrdy, m_err, x_node});
    if (x_ev) chk("field_id", eng_field_id_o, req_field_id_i[oi]);
    fld_hs = x_ev && eng_field_id_rdy_i;
    rsp_hs = x_nrdy && eng_node_valid_i;
    is_null = rsp_hs && (m_id == 8'hFF);
    if (rsp_hs) chk("rsp_node", rsp_node_o, nodef(m_id));
    arb = (o < 0) ? winner(req_valid_i, m_rr) : -1;
    e_acc = eng_field_id_valid_o && eng_field_id_rdy_i;
    e_fid = eng_field_id_o;
    e_del = eng_node_valid_i && eng_node_rdy_o && e_nv;
    g_log.push_back(grant_o);
    if (err_o) err_seen++;
    @(posedge clk);
    #1;
    m_err = is_null;
    if (is_null) m_nulls++;
    if (arb >= 0) begin
      m_owner = arb;
    end else if (fld_hs) begin
      m_out = 1'b1;
      m_last = q_last[oi][0];
      m_id = q_id[oi][0];
      pop(oi);
      open_m[oi] = !m_last;
    end else if (rsp_hs) begin
      m_out = 1'b0;
      rsp_cnt[oi]++;
      if (m_last || is_null) begin
        m_owner = -1;
        m_rr = (oi + 1) % N;
        while (open_m[oi] && q_id[oi].size() > 0) begin
          open_m[oi] = !q_last[oi][0];
          pop(oi);
        end
      end
    end
    if (e_del) begin
      e_busy = 1'b0;
      e_nv = 1'b0;
    end else if (e_busy && !e_nv) begin
      if (e_cnt == 0) e_nv = 1'b1;
      else e_cnt--;
    end
    if (e_acc) begin
      e_busy = 1'b1;
      e_nv = 1'b0;
      e_id = e_fid;
      e_cnt = rnd ? int'($urandom_range(0, 4)) : e_delay;
    end
    drive();
  endtask

  task automatic run_idle(int budget);
    int k;
    bit done;
    k = 0;
    done = (m_owner < 0) && all_empty() && !e_busy;
    while (!done && k < budget) begin
      step();
      k++;
      done = (m_owner < 0) && all_empty() && !e_busy;
    end
    chk("drain", done, 1);
    step();
    step();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    chk("reset_async", outs(), 0);
    for (int r = 0; r < N; r++) begin
      q_id[r].delete();
      q_last[r].delete();
      open_m[r] = 1'b0;
      pause[r] = 1'b0;
      rsp_cnt[r] = 0;
    end
    m_owner = -1;
    m_rr = 0;
    m_out = 1'b0;
    m_last = 1'b0;
    m_err = 1'b0;
    m_nulls = 0;
    e_busy = 1'b0;
    e_nv = 1'b0;
    e_cnt = 0;
    err_seen = 0;
    spur = 1'b0;
    rnd = 1'b0;
    rdy_block = '0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", outs(), 0);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    drive();
    g_log.delete();
  endtask

  task automatic get_order(output int ord, output int gmin,
                           output int gmax);
    logic [N-1:0] prev;
    int z, cnt;
    prev = '0;
    z = 0;
    cnt = 0;
    ord = 0;
    gmin = 999;
    gmax = 0;
    foreach (g_log[i]) begin
      if (g_log[i] == '0) begin
        z++;
      end else if (g_log[i] != prev) begin
        for (int r = 0; r < N; r++)
          if (g_log[i][r]) ord = ord * 16 + r + 1;
        if (cnt > 0) begin
          if (z < gmin) gmin = z;
          if (z > gmax) gmax = z;
        end
        cnt++;
        z = 0;
      end
      prev = g_log[i];
    end
  endtask

  initial begin
    int ord, gmin, gmax, k, bad, nf;
    node_data node0;
    e_delay = 3;
    #2;

    // single requester, two-field message, spurious engine valid
    do_reset();
    spur = 1'b1;
    drive();
    step();
    step();
    spur = 1'b0;
    push(0, 8'd5, 1'b0);
    push(0, 8'd7, 1'b1);
    drive();
    step();
    #1;
    chk("t1_grant", grant_o, 4'b0001);
    run_idle(100);
    chk("t1_rsp_cnt", rsp_cnt[0], 2);
    chk("t1_release", grant_o, 4'b0000);
    push(0, 8'd1, 1'b1);
    push(1, 8'd2, 1'b1);
    drive();
    step();
    #1;
    chk("t1_rr_next", grant_o, 4'b0010);
    run_idle(100);

    // three simultaneous requesters, three-field messages
    do_reset();
    for (int f = 0; f < 3; f++) begin
      push(0, 8'(10 + f), f == 2);
      push(2, 8'(20 + f), f == 2);
      push(3, 8'(30 + f), f == 2);
    end
    drive();
    run_idle(300);
    get_order(ord, gmin, gmax);
    chk("t2_order", ord, 'h134);
    chk("t2_gap", {gmin, gmax}, {32'd1, 32'd1});

    // owner drops valid mid-message while another requester waits
    do_reset();
    push(1, 8'd40, 1'b0);
    push(1, 8'd41, 1'b0);
    push(1, 8'd42, 1'b1);
    drive();
    k = 0;
    while (k < 5 && grant_o !== 4'b0010) begin
      step();
      #1;
      k++;
    end
    chk("t3_grant", grant_o, 4'b0010);
    push(0, 8'd50, 1'b1);
    drive();
    k = 0;
    while (k < 30 && rsp_cnt[1] != 1) begin
      step();
      k++;
    end
    chk("t3_first_rsp", rsp_cnt[1], 1);
    pause[1] = 1'b1;
    drive();
    bad = 0;
    repeat (10) begin
      step();
      #1;
      if (grant_o !== 4'b0010) bad++;
    end
    chk("t3_hold", bad, 0);
    pause[1] = 1'b0;
    drive();
    run_idle(200);
    get_order(ord, gmin, gmax);
    chk("t3_order", ord, 'h21);

    // null node on second field of a four-field message
    do_reset();
    push(3, 8'd60, 1'b0);
    push(3, 8'hFF, 1'b0);
    push(3, 8'd62, 1'b0);
    push(3, 8'd63, 1'b1);
    drive();
    run_idle(200);
    chk("t4_err_pulses", err_seen, 1);
    chk("t4_rsp_cnt", rsp_cnt[3], 2);
    push(0, 8'd70, 1'b1);
    push(3, 8'd71, 1'b1);
    drive();
    step();
    #1;
    chk("t4_rr_wrap", grant_o, 4'b0001);
    run_idle(200);

    // response back-pressure while waiting on the engine
    do_reset();
    push(2, 8'd80, 1'b1);
    push(2, 8'd81, 1'b1);
    rdy_block = 4'b0100;
    drive();
    k = 0;
    while (k < 30 && !(m_out && e_nv)) begin
      step();
      k++;
    end
    #1;
    chk("t5_rsp_valid", rsp_valid_o, 4'b0100);
    node0 = rsp_node_o;
    bad = 0;
    repeat (5) begin
      step();
      #1;
      if (eng_node_rdy_o || eng_field_id_valid_o) bad++;
      if (rsp_node_o !== node0 || rsp_valid_o !== 4'b0100) bad++;
    end
    chk("t5_stall", bad, 0);
    rdy_block = '0;
    drive();
    run_idle(200);
    chk("t5_rsp_cnt", rsp_cnt[2], 2);

    // asynchronous reset while a lookup is outstanding
    do_reset();
    push(1, 8'd90, 1'b0);
    push(1, 8'd91, 1'b1);
    drive();
    k = 0;
    while (k < 30 && !m_out) begin
      step();
      k++;
    end
    #1;
    chk("t6_in_wait", eng_node_rdy_o, 1);
    do_reset();
    push(1, 8'd92, 1'b1);
    push(2, 8'd93, 1'b1);
    drive();
    step();
    #1;
    chk("t6_rr_restart", grant_o, 4'b0010);
    run_idle(200);

    // random messages, pauses, engine delays and back-pressure
    do_reset();
    rnd = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int m = 0; m < 3; m++) begin
        nf = $urandom_range(1, 4);
        for (int f = 0; f < nf; f++)
          push(r, ($urandom_range(0, 15) == 0) ? 8'hFF :
                  8'($urandom_range(0, 254)), f == nf - 1);
      end
    end
    drive();
    run_idle(4000);
    chk("rnd_err_count", err_seen, m_nulls);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
